// File: rtl/clic_nest_stack.sv
// Core-side CLIC consumer: offers the arbiter winner, nests accepted interrupts on a stack, restores threshold on return.
// Optional feature: define CLIC_LATE_ARRIVAL_EN to let a higher-priority request replace a pending, unaccepted offer.
package common_pkg;
    localparam int NR_PRIO_BITS  = 3;
    localparam int NR_INDEX_BITS = 6;
    typedef logic [NR_PRIO_BITS-1:0]  Prio;
    typedef logic [NR_INDEX_BITS-1:0] Index;
endpackage

module clic_nest_stack #(
    parameter int NR_PRIO_BITS  = common_pkg::NR_PRIO_BITS,
    parameter int NR_INDEX_BITS = common_pkg::NR_INDEX_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic [NR_INDEX_BITS-1:0] req_index,
    input  logic [NR_PRIO_BITS-1:0]  req_prio,
    output logic                     take_valid,
    output logic [NR_INDEX_BITS-1:0] take_index,
    output logic [NR_PRIO_BITS-1:0]  take_prio,
    input  logic                     take_ready,
    input  logic                     ret,
    output logic                     clear_valid,
    output logic [NR_INDEX_BITS-1:0] clear_index,
    output logic [NR_PRIO_BITS-1:0]  threshold,
    output logic                     active,
    output logic [NR_INDEX_BITS-1:0] active_index,
    output logic [NR_PRIO_BITS-1:0]  depth,
    output logic                     underflow
);
    // Handshake: an offer (take_valid) is held stable until take_ready is sampled high;
    // the transfer happens on the rising edge where both are high.
    localparam int DEPTH = 2**NR_PRIO_BITS - 1;
    localparam logic [NR_PRIO_BITS-1:0] FULL = '1;
    localparam logic [NR_PRIO_BITS-1:0] ONE  = 1;

    typedef enum logic {IDLE, OFFER} state_t;
    state_t state;

    logic [NR_PRIO_BITS-1:0]  stk_prio  [DEPTH];
    logic [NR_INDEX_BITS-1:0] stk_index [DEPTH];

    logic                     pop, push, offer_ok, late_swap;
    logic [NR_PRIO_BITS-1:0]  depth_pop, depth_nxt, top_prio_nxt;
    logic [NR_INDEX_BITS-1:0] top_index_nxt;

    always_comb begin
        pop      = ret && (depth != '0);
        push     = (state == OFFER) && take_ready;
        offer_ok = req_valid && (req_prio > threshold) && (req_prio != '0);
`ifdef CLIC_LATE_ARRIVAL_EN
        late_swap = (state == OFFER) && !take_ready && req_valid && (req_prio > take_prio);
`else
        late_swap = 1'b0;
`endif
        depth_pop = pop ? (depth - ONE) : depth;
        depth_nxt = push ? (depth_pop + ONE) : depth_pop;
        // Pop is applied before push, so a same-cycle take simply replaces the top.
        top_prio_nxt  = '0;
        top_index_nxt = '0;
        if (push) begin
            top_prio_nxt  = take_prio;
            top_index_nxt = take_index;
        end else if (depth_pop != '0) begin
            top_prio_nxt  = stk_prio[depth_pop - ONE];
            top_index_nxt = stk_index[depth_pop - ONE];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            take_valid   <= 1'b0;
            take_index   <= '0;
            take_prio    <= '0;
            clear_valid  <= 1'b0;
            clear_index  <= '0;
            threshold    <= '0;
            active       <= 1'b0;
            active_index <= '0;
            depth        <= '0;
            underflow    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stk_prio[i]  <= '0;
                stk_index[i] <= '0;
            end
        end else begin
            clear_valid  <= push;
            if (push) begin
                clear_index           <= take_index;
                stk_prio[depth_pop]   <= take_prio;
                stk_index[depth_pop]  <= take_index;
            end
            depth        <= depth_nxt;
            threshold    <= top_prio_nxt;
            active_index <= top_index_nxt;
            active       <= (depth_nxt != '0);
            if (ret && (depth == '0))
                underflow <= 1'b1;

            case (state)
                IDLE: begin
                    if (offer_ok) begin
                        state      <= OFFER;
                        take_valid <= 1'b1;
                        take_index <= req_index;
                        take_prio  <= req_prio;
                    end
                end
                OFFER: begin
                    if (take_ready) begin
                        state      <= IDLE;
                        take_valid <= 1'b0;
                    end else if (late_swap) begin
                        take_index <= req_index;
                        take_prio  <= req_prio;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strictly increasing non-zero priorities bound the nesting depth.
    assert property (@(posedge clk) disable iff (reset) !(push && depth == FULL));

endmodule

// File: doc/clic_nest_stack.md
# clic_nest_stack

Core-side consumer of the CLIC arbiter output. It takes the arbiter's current winning request, offers it to the core with a valid/ready handshake, and on acceptance pushes it onto a nesting stack and clears its pending bit. On handler return it pops the stack and restores the preemption threshold. The threshold is fed back to the arbiter to gate preemption.

## Interface
- `NR_PRIO_BITS`, default 3, priority width. Priority 0 is thread level and is never taken.
- `NR_INDEX_BITS`, default 6, vector index width.
- Stack depth is fixed at 2**NR_PRIO_BITS-1, because nested priorities are strictly increasing and non-zero.

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  1  arbiter has a pending winner
- `req_index`  in  NR_INDEX_BITS  winner vector
- `req_prio`  in  NR_PRIO_BITS  winner priority
- `take_valid`  out  1  offer to core
- `take_index`  out  NR_INDEX_BITS  offered vector
- `take_prio`  out  NR_PRIO_BITS  offered priority
- `take_ready`  in  1  core accepts offer
- `ret`  in  1  core returns from current handler (one-cycle pulse)
- `clear_valid`  out  1  pulse: clear pending bit
- `clear_index`  out  NR_INDEX_BITS  vector to clear
- `threshold`  out  NR_PRIO_BITS  priority at top of stack, 0 when empty
- `active`  out  1  stack non-empty
- `active_index`  out  NR_INDEX_BITS  vector at top of stack
- `depth`  out  NR_PRIO_BITS  stack occupancy
- `underflow`  out  1  sticky: `ret` seen with empty stack

## Operation
- Types and widths come from `common_pkg`: `Prio` and `Index`.
- Two-state FSM, `IDLE` and `OFFER`.
- **IDLE → OFFER** when `req_valid && req_prio > threshold && req_prio != 0`.
  - Capture `req_index`/`req_prio` into the take registers.
- **OFFER → IDLE** when `take_ready` is high.
  - Push {take_index, take_prio}.
  - `clear_valid`=1 with `clear_index`=take_index for one cycle.
- **OFFER, `take_ready` low:** offer is held stable.
  - This holds even if `req_valid` drops or `req_index` changes.
  - Exception: late-arrival replacement, see Configuration.
- **`ret` with depth>0:** pop the stack.
  - `threshold`, `active_index` and `active` follow the new top.
- **`ret` with depth==0:** ignored; set `underflow` (cleared only by reset).
- **`ret` and a take handshake in the same cycle:** pop is applied first, then push.
  - Net depth is unchanged and the top is replaced by the taken entry.
  - Legal because take_prio > old threshold ≥ post-pop threshold.
- **`ret` during `OFFER` without handshake:** offer is retained, since its priority still exceeds the lowered threshold.
- Push at full stack cannot occur by construction. Assertion: never push when depth==2**NR_PRIO_BITS-1.

## Timing
- Reset values, next edge after `reset` high:
  - State `IDLE`.
  - `take_valid`, `clear_valid`, `active`, `underflow` = 0.
  - `take_index`, `take_prio`, `clear_index`, `threshold`, `active_index`, `depth` = 0.
  - Stack contents cleared.
- Reset mid-offer or mid-nest: all of the above; no `clear_valid` is emitted.
- Latencies:
  - Request to `take_valid`: 1 cycle.
  - Handshake edge to push, `clear_valid` pulse and new `threshold`: same edge. All are visible the cycle after `take_ready` is sampled high.
  - `ret` to restored `threshold`: 1 cycle.
- After a push, the next offer is evaluated against the new threshold in the first `IDLE` cycle. No back-to-back offer against a stale threshold.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `CLIC_LATE_ARRIVAL_EN` defined:
  - In `OFFER` with `take_ready` low, if `req_valid && req_prio > take_prio`, the take registers load the new request at the next edge. `take_valid` stays high.
  - A handshake in the same cycle wins; no replacement occurs.
- Not defined: the offer is locked until taken.

## Test plan
- Reset, then `req_valid`=1, index 5, prio 3 → next cycle `take_valid`=1, `take_index`=5. Assert `take_ready` → `clear_valid` pulse index 5, `threshold`=3, `depth`=1, `active_index`=5.
- Nesting: index 9 prio 2 is offered and accepted. Then index 4 prio 6 is offered and accepted. Then index 7 prio 6 → index 7 is never offered (6 ≯ 6). Then `ret` → `threshold`=2, `depth`=1, `active_index`=9.
- `ret` with depth 0 → `underflow`=1; depth and threshold stay 0; `underflow` persists until reset.
- `ret` and `take_ready` in the same cycle: stack [prio 2, idx 1], offer idx 3 prio 5 → depth stays 1, `threshold`=5, `active_index`=3.
- With `CLIC_LATE_ARRIVAL_EN`: offer idx 2 prio 1, `take_ready` low, then `req` idx 8 prio 4 → `take_index`=8 next cycle. Without the macro, `take_index` stays 2.
- Reset asserted during `OFFER` with depth 2 → next cycle all outputs 0; no `clear_valid`.
